timer_arbiter: RTL and testbench
================================

# timer_arbiter

Shared interval timer arbitrated among `N_REQ` requesters; each requester asks for a delay of `dur` seconds-scale ticks and receives a one-cycle `done` pulse when it expires. An internal prescaler divides `clk_in` into ticks, so a single counter chain serves every lab module that needs second-level delays (blinkers, display hold, debounce windows). Sits between the 50 MHz board clock domain and user FSMs.

## Interface
- `N_REQ`, 4, number of requesters (2..8).
- `DIV`, 50_000_000, `clk_in` cycles per tick (≥2).
- `DUR_W`, 8, width of each duration field in ticks.
- `clk_in` in 1: 50 MHz system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in `N_REQ`: level request per requester; must stay high until `done` or the request is abandoned.
- `dur` in `N_REQ*DUR_W`: packed durations, requester i at bits `[i*DUR_W +: DUR_W]`; sampled only at grant.
- `grant` out `N_REQ`: one-hot, high while that requester owns the timer.
- `done` out `N_REQ`: one-cycle pulse on the owner's bit at expiry.
- `busy` out 1: high in RUN and DONE.
- `tick` out 1: one-cycle pulse at each prescaler wrap while in RUN.
- `remaining` out `DUR_W`: ticks left for current owner; 0 when idle.

## Operation
- All outputs registered. Reset values: `grant`=0, `done`=0, `busy`=0, `tick`=0, `remaining`=0, prescaler=0, state IDLE, RR pointer=`N_REQ-1`.
- States IDLE, RUN, DONE.
- IDLE: if `req`≠0, pick winner w; next edge: `grant`=1<<w, `remaining`=dur[w], prescaler=0, pointer=w. If dur[w]≠0 go RUN; if dur[w]=0 go DONE directly (`done[w]`=1, `grant`=0).
- RUN: prescaler counts 0..DIV-1. At DIV-1: prescaler←0, `tick`=1 next cycle, `remaining`←`remaining`-1; if `remaining` was 1, go DONE with `done`=`grant`, `grant`=0, `remaining`=0.
- RUN abort: if `req[w]` is low at a clock edge, next edge: `grant`=0, `remaining`=0, prescaler=0, no `done`, state IDLE. Abort takes precedence over a same-cycle expiry.
- DONE: lasts exactly one cycle (`done` high), then IDLE with `done`=0. Requests from other requesters during RUN/DONE are held pending, never lost while `req` stays high.
- Requester that keeps `req` high after its `done` is eligible again on the next IDLE arbitration.
- Prescaler width = clog2(DIV); `remaining` never wraps below 0.

## Timing
- Grant latency: `req` high before edge k in IDLE → `grant` high after edge k.
- Expiry: `done` rises exactly dur×DIV cycles after `grant` rises; `grant` falls on the same edge.
- `tick` pulses at grant-edge + n×DIV for n=1..dur.
- Turnaround: next `grant` earliest 2 cycles after `done` rises (DONE, then IDLE sample).
- dur=0: `done` rises 1 cycle after `req` sampled, `grant` never asserted.
- `rst` mid-RUN: all outputs clear immediately (asynchronous), no `done` emitted.

## Configuration
- `TIMER_ARB_RR_EN` defined: round-robin; search starts at pointer+1 modulo `N_REQ`, so after reset requester 0 wins first.
- Undefined: fixed priority, lowest index wins; pointer unused. Ports and timing identical in both builds.

## Test plan
- DIV=4, req[1]=1, dur[1]=3 → `grant`=4'b0010 next cycle, `tick` at +4,+8,+12, `done`=4'b0010 at +12, `remaining` 3→2→1→0.
- req[2] with dur[2]=0 → `done[2]` one cycle later, `grant` stays 0, `busy` high 1 cycle.
- req[0] and req[3] together, both kept high, dur=1, RR build → grants 0,3,0,3; fixed-priority build → 0,0,0 (3 starved).
- Drop req[1] at 5 cycles into a dur=3, DIV=4 run → `grant`=0 next cycle, no `done`, `remaining`=0, pending req[2] granted 1 cycle later.
- Assert `rst` mid-RUN for 1 ns between edges → all outputs 0 immediately; after release, still-high req regranted at first edge.
- DIV=2, DUR_W=8, dur=255 → `done` exactly 510 cycles after grant, no wrap of `remaining`.

Source files
------------

// File: rtl/timer_arbiter.sv
// Interval timer with a tick prescaler, shared by N_REQ level requesters; registered outputs, 1-cycle grant latency.
// Fixed priority by default; define TIMER_ARB_RR_EN for round-robin arbitration.
module timer_arbiter #(
  parameter int N_REQ = 4,
  parameter int DIV   = 50_000_000,
  parameter int DUR_W = 8
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*DUR_W-1:0] dur,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   tick,
  output logic [DUR_W-1:0]       remaining
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
  localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             busy_q, busy_d;
  logic             tick_q, tick_d;
  logic [DUR_W-1:0] remaining_q, remaining_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [IW-1:0]    win_idx, cand;
  logic             win_found;
  logic [DUR_W-1:0] win_dur;

`ifdef TIMER_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;

  // Search begins one past the last winner so every requester gets a turn.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && win_found) ptr_d = win_idx;
  end
`else
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IW'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end
`endif

  always_comb begin
    win_dur = '0;
    for (int k = 0; k < N_REQ; k++)
      if (win_idx == IW'(k)) win_dur = dur[k*DUR_W +: DUR_W];
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    done_d      = '0;
    tick_d      = 1'b0;
    remaining_d = remaining_q;
    presc_d     = presc_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          presc_d     = '0;
          remaining_d = win_dur;
          if (win_dur != '0) begin
            state_d = ST_RUN;
            grant_d = ONE << win_idx;
          end else begin
            state_d = ST_DONE;
            grant_d = '0;
            done_d  = ONE << win_idx;
          end
        end
      end
      ST_RUN: begin
        // A dropped request wins over an expiry landing on the same edge.
        if ((req & grant_q) == '0) begin
          state_d     = ST_IDLE;
          grant_d     = '0;
          remaining_d = '0;
          presc_d     = '0;
        end else if (presc_q == PRE_LAST) begin
          presc_d     = '0;
          tick_d      = 1'b1;
          remaining_d = remaining_q - DUR_W'(1);
          if (remaining_q <= DUR_W'(1)) begin
            state_d     = ST_DONE;
            done_d      = grant_q;
            grant_d     = '0;
            remaining_d = '0;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      tick_q      <= 1'b0;
      remaining_q <= '0;
      presc_q     <= '0;
`ifdef TIMER_ARB_RR_EN
      ptr_q       <= IW'(N_REQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      tick_q      <= tick_d;
      remaining_q <= remaining_d;
      presc_q     <= presc_d;
`ifdef TIMER_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign tick      = tick_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: DIV=4 instance for arbitration/abort/reset, DIV=2 instance for a full 255-tick run.
module tb_timer_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk_in = 1'b0;
  logic         rst    = 1'b1;
  logic [N-1:0] req    = '0;
  logic [N-1:0] req2   = '0;
  logic [N*W-1:0] dur  = '0;
  logic [N*W-1:0] dur2 = '0;
  logic [N-1:0] grant, done, grant2, done2;
  logic         busy, tick, busy2, tick2;
  logic [W-1:0] remaining, remaining2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int           cyc;
    logic [N-1:0] vec;
  } exp_t;
  exp_t sbq[$];
  exp_t sbq2[$];
  exp_t e1, e2;

  timer_arbiter #(.N_REQ(N), .DIV(4), .DUR_W(W)) u_dut (
    .clk_in(clk_in), .rst(rst), .req(req), .dur(dur),
    .grant(grant), .done(done), .busy(busy), .tick(tick), .remaining(remaining)
  );

  timer_arbiter #(.N_REQ(N), .DIV(2), .DUR_W(W)) u_dut2 (
    .clk_in(clk_in), .rst(rst), .req(req2), .dur(dur2),
    .grant(grant2), .done(done2), .busy(busy2), .tick(tick2), .remaining(remaining2)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Every done pulse must match the next scoreboard entry in vector and cycle.
  always @(negedge clk_in) begin
    if (!rst && done !== '0) begin
      if (sbq.size() == 0) chk("done_unexpected", 32'(done), 0);
      else begin
        e1 = sbq.pop_front();
        chk("done_vec", 32'(done), 32'(e1.vec));
        chk("done_cyc", cyc, e1.cyc);
      end
    end
  end

  always @(negedge clk_in) begin
    if (!rst && done2 !== '0) begin
      if (sbq2.size() == 0) chk("done2_unexpected", 32'(done2), 0);
      else begin
        e2 = sbq2.pop_front();
        chk("done2_vec", 32'(done2), 32'(e2.vec));
        chk("done2_cyc", cyc, e2.cyc);
      end
    end
  end

  initial begin
    int g;
    int ev;

    // Reset state
    step(2);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_remaining", 32'(remaining), 0);
    chk("rst_grant2", 32'(grant2), 0);
    rst = 1'b0;
    step(1);
    chk("idle_busy", 32'(busy), 0);

    // req0 and req3 both held, dur=1: RR alternates, fixed priority starves 3
    dur[0*W +: W] = 8'd1;
    dur[3*W +: W] = 8'd1;
    req = 4'b1001;
    g = cyc + 1;
    for (int r = 0; r < 4; r++) begin
`ifdef TIMER_ARB_RR_EN
      ev = (r % 2 == 0) ? 1 : 8;
`else
      ev = 1;
`endif
      sbq.push_back('{cyc: g + 6 * r + 4, vec: N'(ev)});
    end
    for (int r = 0; r < 4; r++) begin
`ifdef TIMER_ARB_RR_EN
      ev = (r % 2 == 0) ? 1 : 8;
`else
      ev = 1;
`endif
      step(1);
      chk("pair_grant", 32'(grant), ev);
      chk("pair_remaining", 32'(remaining), 1);
      step(4);
      chk("pair_grant_off", 32'(grant), 0);
      chk("pair_busy_done", 32'(busy), 1);
      if (r == 3) req = '0;
      step(1);
    end
    chk("pair_idle_busy", 32'(busy), 0);
    step(1);

    // req1 with dur=3: ticks at +4,+8,+12, done at +12
    dur[1*W +: W] = 8'd3;
    req = 4'b0010;
    g = cyc + 1;
    sbq.push_back('{cyc: g + 12, vec: 4'b0010});
    step(1);
    chk("a_grant", 32'(grant), 2);
    chk("a_rem0", 32'(remaining), 3);
    chk("a_busy", 32'(busy), 1);
    chk("a_tick0", 32'(tick), 0);
    step(3);
    chk("a_tick3", 32'(tick), 0);
    chk("a_rem3", 32'(remaining), 3);
    step(1);
    chk("a_tick4", 32'(tick), 1);
    chk("a_rem4", 32'(remaining), 2);
    step(1);
    chk("a_tick5", 32'(tick), 0);
    step(3);
    chk("a_tick8", 32'(tick), 1);
    chk("a_rem8", 32'(remaining), 1);
    step(4);
    chk("a_tick12", 32'(tick), 1);
    chk("a_rem12", 32'(remaining), 0);
    chk("a_grant12", 32'(grant), 0);
    chk("a_done12", 32'(done), 2);
    chk("a_busy12", 32'(busy), 1);
    req = '0;
    step(1);
    chk("a_busy13", 32'(busy), 0);
    chk("a_done13", 32'(done), 0);
    chk("a_tick13", 32'(tick), 0);
    step(1);

    // dur=0: done one cycle after sampling, grant never asserted
    dur[2*W +: W] = 8'd0;
    req = 4'b0100;
    sbq.push_back('{cyc: cyc + 1, vec: 4'b0100});
    step(1);
    chk("z_done", 32'(done), 4);
    chk("z_grant", 32'(grant), 0);
    chk("z_busy", 32'(busy), 1);
    chk("z_rem", 32'(remaining), 0);
    req = '0;
    step(1);
    chk("z_busy_off", 32'(busy), 0);
    chk("z_done_off", 32'(done), 0);
    step(1);

    // Abort: drop req1 five cycles into its run, pending req2 served next
    dur[1*W +: W] = 8'd3;
    dur[2*W +: W] = 8'd1;
    req = 4'b0110;
    g = cyc + 1;
    sbq.push_back('{cyc: g + 11, vec: 4'b0100});
    step(1);
    chk("ab_grant1", 32'(grant), 2);
    step(5);
    chk("ab_rem5", 32'(remaining), 2);
    req = 4'b0100;
    step(1);
    chk("ab_grant_off", 32'(grant), 0);
    chk("ab_rem_off", 32'(remaining), 0);
    chk("ab_done_off", 32'(done), 0);
    chk("ab_busy_off", 32'(busy), 0);
    step(1);
    chk("ab_grant2", 32'(grant), 4);
    chk("ab_rem2", 32'(remaining), 1);
    step(4);
    chk("ab_done2", 32'(done), 4);
    req = '0;
    step(2);

    // Asynchronous reset pulse mid-run
    dur[0*W +: W] = 8'd5;
    req = 4'b0001;
    step(1);
    chk("r_grant", 32'(grant), 1);
    step(3);
    #2;
    rst = 1'b1;
    #1;
    chk("r_grant_clr", 32'(grant), 0);
    chk("r_busy_clr", 32'(busy), 0);
    chk("r_rem_clr", 32'(remaining), 0);
    chk("r_tick_clr", 32'(tick), 0);
    chk("r_done_clr", 32'(done), 0);
    rst = 1'b0;
    step(1);
    chk("r_regrant", 32'(grant), 1);
    chk("r_rem_regrant", 32'(remaining), 5);
    req = '0;
    step(1);
    chk("r_abort_grant", 32'(grant), 0);
    step(1);

    // DIV=2 instance, dur=255: done exactly 510 cycles after grant
    dur2[0 +: W] = 8'd255;
    req2 = 4'b0001;
    g = cyc + 1;
    sbq2.push_back('{cyc: g + 510, vec: 4'b0001});
    step(1);
    chk("l_grant", 32'(grant2), 1);
    chk("l_rem0", 32'(remaining2), 255);
    step(2);
    chk("l_rem2", 32'(remaining2), 254);
    chk("l_tick2", 32'(tick2), 1);
    step(507);
    chk("l_rem509", 32'(remaining2), 1);
    chk("l_grant509", 32'(grant2), 1);
    step(1);
    chk("l_done510", 32'(done2), 1);
    chk("l_grant510", 32'(grant2), 0);
    chk("l_rem510", 32'(remaining2), 0);
    chk("l_busy510", 32'(busy2), 1);
    req2 = '0;
    step(2);
    chk("l_idle", 32'(busy2), 0);

    chk("sb_empty", sbq.size(), 0);
    chk("sb2_empty", sbq2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
